// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: MEM-stage word load/store controller for an async SRAM.
// Splits each pipeline word into little-endian SRAM beats and stalls until done.
module sram_word_ctrl #(
  parameter int DATA_W    = 32,
  parameter int SRAM_W    = 16,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 1024,
  parameter int BEAT_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);
  localparam int N  = DATA_W / SRAM_W;
  localparam int NB = $clog2(N);
  localparam int WS = $clog2(DATA_W / 8);
  localparam int BW = (N > 1) ? NB : 1;
  localparam int CW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(N - 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(BEAT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     beat_nx;
  logic [CW-1:0]     cyc;
  logic [CW-1:0]     cyc_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] word_base;
  logic [DATA_W-1:0] wdata_q;
  logic [SRAM_W-1:0] dq_out;
  logic              dq_oe;

  // word index scaled to SRAM beats; wraps silently in ADDR_W bits
  assign word_base =
    ADDR_W'(((addr - 32'(BASE_ADDR)) >> WS) << NB);

  assign beat_nx = beat + BW'(1);
  assign cyc_nx  = cyc + CW'(1);

  assign freeze = rst & (wr_en | rd_en) & (state != DONE);

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_W{1'bz}};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      cyc       <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (state == READ && cyc == CYC_LAST)
        rdata[beat*SRAM_W +: SRAM_W] <= SRAM_DQ;
      unique case (state)
        IDLE: begin
          beat <= '0;
          cyc  <= '0;
          if (wr_en | rd_en) begin
            base_q    <= word_base;
            wdata_q   <= wdata;
            SRAM_ADDR <= word_base;
            if (wr_en) begin
              state     <= WRITE;
              SRAM_WE_N <= 1'b0;
              SRAM_OE_N <= 1'b1;
              dq_out    <= wdata[SRAM_W-1:0];
              dq_oe     <= 1'b1;
            end else begin
              state     <= READ;
              SRAM_WE_N <= 1'b1;
              SRAM_OE_N <= 1'b0;
            end
          end
        end
        WRITE, READ: begin
          if (cyc == CYC_LAST) begin
            cyc <= '0;
            if (beat == BEAT_LAST) begin
              state     <= DONE;
              ready     <= 1'b1;
              beat      <= '0;
              SRAM_WE_N <= 1'b1;
              SRAM_OE_N <= 1'b0;
              dq_oe     <= 1'b0;
            end else begin
              beat      <= beat_nx;
              SRAM_ADDR <= base_q + ADDR_W'(beat_nx);
              if (state == WRITE) begin
                SRAM_WE_N <= 1'b0;
                dq_out    <= wdata_q[beat_nx*SRAM_W +: SRAM_W];
              end
            end
          end else begin
            cyc <= cyc_nx;
            // last cycle of a write beat releases WE_N with data held
            if (state == WRITE)
              SRAM_WE_N <= (cyc_nx == CYC_LAST);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb_sram_word_ctrl: directed vectors for sram_word_ctrl with SRAM models.
// Covers default 32/16/2 and a 64-bit, three-cycle-beat instance.
module tb_sram_word_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic wr;
  logic rd;
  logic [31:0] addr;
  logic [63:0] wdata;

  always #5 clk = ~clk;

  wire        wr0 = wr & ~sel;
  wire        rd0 = rd & ~sel;
  wire        wr1 = wr & sel;
  wire        rd1 = rd & sel;

  logic [31:0] rdata0;
  logic        rdy0, fz0, we0, oe0, ce0, ub0, lb0;
  logic [17:0] a0;
  wire  [15:0] dq0;
  logic [63:0] rdata1;
  logic        rdy1, fz1, we1, oe1, ce1, ub1, lb1;
  logic [17:0] a1;
  wire  [15:0] dq1;

  sram_word_ctrl u0 (
    .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0),
    .addr(addr), .wdata(wdata[31:0]), .rdata(rdata0),
    .ready(rdy0), .freeze(fz0), .SRAM_ADDR(a0),
    .SRAM_DQ(dq0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0),
    .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
  );

  sram_word_ctrl #(.DATA_W(64), .BEAT_CYC(3)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1),
    .addr(addr), .wdata(wdata), .rdata(rdata1),
    .ready(rdy1), .freeze(fz1), .SRAM_ADDR(a1),
    .SRAM_DQ(dq1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1),
    .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );

  // simple async SRAM models indexed by the low address byte
  logic [15:0] mem0 [0:255] = '{default: 16'h0};
  logic [15:0] mem1 [0:255] = '{default: 16'h0};
  assign dq0 = (!oe0 && we0) ? mem0[a0[7:0]] : 16'hzzzz;
  assign dq1 = (!oe1 && we1) ? mem1[a1[7:0]] : 16'hzzzz;
  always @(posedge clk) if (!we0) mem0[a0[7:0]] <= dq0;
  always @(posedge clk) if (!we1) mem1[a1[7:0]] <= dq1;

  wire        frz    = sel ? fz1 : fz0;
  wire        rdy    = sel ? rdy1 : rdy0;
  wire        s_we   = sel ? we1 : we0;
  wire [17:0] s_addr = sel ? a1 : a0;
  wire [63:0] s_rd   = sel ? rdata1 : {32'h0, rdata0};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input bit s, input logic w, input logic r,
    input logic [31:0] a, input logic [63:0] d,
    input logic [17:0] base, input int n, input int bc,
    output int fz, output int rc, output int welo, output int aerr);
    fz = 0; rc = -1; welo = 0; aerr = 0;
    @(negedge clk);
    sel = s; wr = w; rd = r; addr = a; wdata = d;
    for (int c = 0; c < 64 && rc < 0; c++) begin
      #1;
      if (frz) fz++;
      if (!s_we) welo++;
      if (c >= 1 && c <= n*bc && s_addr != base + 18'((c-1)/bc))
        aerr++;
      if (rdy) begin
        rc = c; wr = 1'b0; rd = 1'b0;
      end
      @(negedge clk);
    end
    #1;
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [17:0] base;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  vec_t vt [8];

  initial begin
    int fz, rc, welo, aerr, n;
    vt[0] = '{1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 32'h0,
              18'd4, 16'hBEEF, 16'hDEAD};
    vt[1] = '{1'b0, 1'b1, 32'd1032, 32'h0, 32'hDEADBEEF,
              18'd4, 16'hBEEF, 16'hDEAD};
    vt[2] = '{1'b1, 1'b1, 32'd1024, 32'h1, 32'hDEADBEEF,
              18'd0, 16'h0001, 16'h0000};
    vt[3] = '{1'b1, 1'b0, 32'd1040, 32'h12345678, 32'hDEADBEEF,
              18'd8, 16'h5678, 16'h1234};
    vt[4] = '{1'b0, 1'b1, 32'd1040, 32'h0, 32'h12345678,
              18'd8, 16'h5678, 16'h1234};
    vt[5] = '{1'b0, 1'b1, 32'd1024, 32'h0, 32'h00000001,
              18'd0, 16'h0001, 16'h0000};
    vt[6] = '{1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 32'h00000001,
              18'h3FFFE, 16'h5A5A, 16'hA5A5};
    vt[7] = '{1'b0, 1'b1, 32'd1020, 32'h0, 32'hA5A55A5A,
              18'h3FFFE, 16'h5A5A, 16'hA5A5};

    rst = 1'b0; sel = 1'b0; wr = 1'b1; rd = 1'b0;
    addr = 32'd0; wdata = 64'd0;
    #12;
    chk("rst_ready", 64'(rdy0), 64'd0);
    chk("rst_rdata", 64'(rdata0), 64'd0);
    chk("rst_freeze", 64'(fz0), 64'd0);
    chk("rst_we_n", 64'(we0), 64'd1);
    chk("rst_oe_n", 64'(oe0), 64'd0);
    chk("rst_addr", 64'(a0), 64'd0);
    chk("ties", 64'({ce0, ub0, lb0, ce1, ub1, lb1}), 64'd0);
    chk("rst_rdata1", rdata1, 64'd0);
    @(negedge clk);
    wr = 1'b0; rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run(1'b0, vt[i].w, vt[i].r, vt[i].a, {32'h0, vt[i].d},
          vt[i].base, 2, 2, fz, rc, welo, aerr);
      chk($sformatf("v%0d_freeze", i), 64'(fz), 64'd5);
      chk($sformatf("v%0d_ready_cyc", i), 64'(rc), 64'd5);
      chk($sformatf("v%0d_ready_pulse", i), 64'(rdy), 64'd0);
      chk($sformatf("v%0d_we_low", i), 64'(welo),
          vt[i].w ? 64'd2 : 64'd0);
      chk($sformatf("v%0d_addr_seq", i), 64'(aerr), 64'd0);
      chk($sformatf("v%0d_rdata", i), s_rd, {32'h0, vt[i].exp_rd});
      chk($sformatf("v%0d_mem_lo", i),
          64'(mem0[vt[i].base[7:0]]), 64'(vt[i].lo));
      chk($sformatf("v%0d_mem_hi", i),
          64'(mem0[vt[i].base[7:0] + 8'd1]), 64'(vt[i].hi));
    end

    // back-to-back reads with rd_en held across DONE
    @(negedge clk);
    sel = 1'b0; rd = 1'b1; addr = 32'd1040;
    n = -1;
    for (int c = 0; c < 20 && n < 0; c++) begin
      #1;
      if (rdy) n = c; else @(negedge clk);
    end
    chk("b2b_first_cyc", 64'(n), 64'd5);
    chk("b2b_done_freeze", 64'(frz), 64'd0);
    chk("b2b_first_rdata", s_rd, 64'h12345678);
    addr = 32'd1024;
    @(negedge clk);
    #1;
    chk("b2b_restart_freeze", 64'(frz), 64'd1);
    chk("b2b_restart_ready", 64'(rdy), 64'd0);
    n = -1;
    for (int c = 0; c < 20 && n < 0; c++) begin
      if (rdy) n = c; else @(negedge clk);
      #1;
    end
    rd = 1'b0;
    chk("b2b_second_cyc", 64'(n), 64'd5);
    chk("b2b_second_rdata", s_rd, 64'h1);

    // reset in the hold cycle of beat 0 of a write
    @(negedge clk);
    sel = 1'b0; wr = 1'b1; addr = 32'd1024; wdata = 64'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_we_n", 64'(we0), 64'd1);
    chk("mid_rst_oe_n", 64'(oe0), 64'd0);
    chk("mid_rst_freeze", 64'(fz0), 64'd0);
    chk("mid_rst_addr", 64'(a0), 64'd0);
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_mem0", 64'(mem0[0]), 64'hF00D);
    chk("mid_rst_mem1", 64'(mem0[1]), 64'h0000);
    chk("mid_rst_rdata", 64'(rdata0), 64'd0);

    // 64-bit word, three-cycle beats
    run(1'b1, 1'b1, 1'b0, 32'd1032, 64'h0123456789ABCDEF,
        18'd4, 4, 3, fz, rc, welo, aerr);
    chk("w64_freeze", 64'(fz), 64'd13);
    chk("w64_ready_cyc", 64'(rc), 64'd13);
    chk("w64_we_low", 64'(welo), 64'd8);
    chk("w64_addr_seq", 64'(aerr), 64'd0);
    chk("w64_mem", {mem1[7], mem1[6], mem1[5], mem1[4]},
        64'h0123456789ABCDEF);
    run(1'b1, 1'b0, 1'b1, 32'd1032, 64'd0,
        18'd4, 4, 3, fz, rc, welo, aerr);
    chk("r64_freeze", 64'(fz), 64'd13);
    chk("r64_ready_cyc", 64'(rc), 64'd13);
    chk("r64_we_low", 64'(welo), 64'd0);
    chk("r64_addr_seq", 64'(aerr), 64'd0);
    chk("r64_rdata", s_rd, 64'h0123456789ABCDEF);
    chk("r64_ready_pulse", 64'(rdy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
